// File: rtl/spi_ram_arbiter.sv
// Two-master round-robin arbiter in front of the mapped SPI RAM word port.
// Each master gets a one-deep request latch; requests are replayed to the RAM as single strobes.
module spi_ram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_rd,
    input  logic              m0_wr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_busy,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_rd,
    input  logic              m1_wr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_busy,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_rd,
    output logic              s_wr,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rbusy,
    input  logic              s_wbusy,
    output logic              err_overrun
);

    // state | meaning
    // IDLE  | no transaction in flight, pick an owner if anything is pending
    // ISSUE | owner's request on s_addr/s_wdata, single s_rd or s_wr pulse
    // WAIT  | slave working (s_rbusy | s_wbusy)
    // DONE  | capture read data, release owner's pending flag
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [1:0]        stb, accept, pend, lat_wr;
    logic [ADDR_W-1:0] lat_addr  [2];
    logic [DATA_W-1:0] lat_wdata [2];
    logic              owner, last_grant, grant, op_wr;

    assign stb = {m1_rd | m1_wr, m0_rd | m0_wr};

    // The owner's slot frees up in DONE, so a strobe arriving then is a new request, not an overrun.
    assign accept[0] = stb[0] & (~pend[0] | (state == DONE && !owner));
    assign accept[1] = stb[1] & (~pend[1] | (state == DONE && owner));
    assign grant     = (&pend) ? ~last_grant : pend[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= '0;
            lat_wr       <= '0;
            lat_addr[0]  <= '0;
            lat_addr[1]  <= '0;
            lat_wdata[0] <= '0;
            lat_wdata[1] <= '0;
            err_overrun  <= 1'b0;
        end else begin
            if (accept[0]) begin
                pend[0]      <= 1'b1;
                lat_addr[0]  <= m0_addr;
                lat_wdata[0] <= m0_wdata;
                lat_wr[0]    <= m0_wr;
            end else if (state == DONE && !owner) begin
                pend[0] <= 1'b0;
            end
            if (accept[1]) begin
                pend[1]      <= 1'b1;
                lat_addr[1]  <= m1_addr;
                lat_wdata[1] <= m1_wdata;
                lat_wr[1]    <= m1_wr;
            end else if (state == DONE && owner) begin
                pend[1] <= 1'b0;
            end
            err_overrun <= err_overrun | (|(stb & ~accept));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_wr      <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (state == IDLE && (|pend)) begin
                owner   <= grant;
                op_wr   <= lat_wr[grant];
                s_addr  <= lat_addr[grant];
                s_wdata <= lat_wdata[grant];
            end
            if (state == DONE) begin
                last_grant <= owner;
                if (!op_wr) begin
                    if (owner) m1_rdata <= s_rdata;
                    else       m0_rdata <= s_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|pend) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (!(s_rbusy || s_wbusy)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign s_rd    = (state == ISSUE) && !op_wr;
    assign s_wr    = (state == ISSUE) && op_wr;
    assign m0_busy = pend[0] | (state != IDLE && !owner);
    assign m1_busy = pend[1] | (state != IDLE && owner);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: SPI RAM slave model, vector table, corner sequences,
// and a random two-master run checked against a transaction-level round-robin model.
module tb_spi_ram_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0, s_addr;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic m0_rd = 0, m0_wr = 0, m1_rd = 0, m1_wr = 0, m0_busy, m1_busy;
    logic s_rd, s_wr, s_rbusy, s_wbusy, err_overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_rdata(m0_rdata), .m0_busy(m0_busy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_rdata(m1_rdata), .m1_busy(m1_busy),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd), .s_wr(s_wr),
        .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
        .err_overrun(err_overrun)
    );

    // SPI RAM model: busy for blen cycles starting the cycle after a strobe.
    // Never-written words read as 0xA5000000 | index.
    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cyc;
    } sop_t;

    sop_t        sq[$];
    int          cyc = 0;
    int          blen = 3;
    int          bcnt;
    logic        bwr;
    logic [DW-1:0] smem [256];
    bit          swritten [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= 0;
            bwr     <= 1'b0;
            s_rdata <= '0;
        end else begin
            if (s_rd || s_wr) begin
                sq.push_back('{s_rd, s_wr, s_addr, s_wdata, cyc});
                bcnt <= blen;
                bwr  <= s_wr;
                if (s_wr) begin
                    smem[s_addr[7:0]]     <= s_wdata;
                    swritten[s_addr[7:0]] <= 1'b1;
                end else begin
                    s_rdata <= swritten[s_addr[7:0]] ? smem[s_addr[7:0]] : (32'hA500_0000 | 32'(s_addr[7:0]));
                end
            end else if (bcnt > 0) begin
                bcnt <= bcnt - 1;
            end
        end
    end

    assign s_rbusy = (bcnt != 0) && !bwr;
    assign s_wbusy = (bcnt != 0) && bwr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_stb();
        m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    endtask

    task automatic drive(input int n, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d; end
        else        begin m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic do_reset();
        clear_stb();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m0_busy || m1_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 64'(n < 300), 64'd1);
    endtask

    // Vector table: op bit0 = rd, bit1 = wr; each vector starts from reset (m0 has priority).
    typedef struct {
        logic [1:0]    op0, op1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int            bl;
        int            n;
        logic [1:0]    ewr;
        logic [AW-1:0] ea0, ea1;
        logic [DW-1:0] ed0, ed1, r0, r1;
    } vec_t;

    vec_t vt[8];

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        do_reset();
        blen = v.bl;
        base = sq.size();
        drive(0, v.op0[0], v.op0[1], v.a0, v.d0);
        drive(1, v.op1[0], v.op1[1], v.a1, v.d1);
        @(negedge clk);
        clear_stb();
        wait_idle($sformatf("vec%0d", idx));
        chk($sformatf("vec%0d_nops", idx), 64'(sq.size() - base), 64'(v.n));
        for (int i = 0; i < v.n && base + i < sq.size(); i++) begin
            chk($sformatf("vec%0d_op%0d_wr", idx, i), {sq[base+i].rd, sq[base+i].wr}, {~v.ewr[i], v.ewr[i]});
            chk($sformatf("vec%0d_op%0d_addr", idx, i), sq[base+i].addr, (i == 0) ? v.ea0 : v.ea1);
            if (v.ewr[i])
                chk($sformatf("vec%0d_op%0d_wdata", idx, i), sq[base+i].wdata, (i == 0) ? v.ed0 : v.ed1);
        end
        chk($sformatf("vec%0d_m0_rdata", idx), m0_rdata, v.r0);
        chk($sformatf("vec%0d_m1_rdata", idx), m1_rdata, v.r1);
        chk($sformatf("vec%0d_err", idx), err_overrun, 0);
    endtask

    // Random-phase reference model: one request slot per master, plain round-robin.
    int            mst[2];
    logic          mwr[2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mdata[2];
    int            mcyc[2];
    logic [DW-1:0] lastr[2];
    logic [DW-1:0] rmem [256];
    int            last_g;

    initial begin
        int base, fall, wr_cnt, rd_cnt, wr_cyc, cnt0, cnt1, rdptr, r;
        logic b1, m1b;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        sop_t op;

        vt[0] = '{2'd2, 2'd0, 20'h10, 20'h0,  32'hDEADBEEF, 32'h0,        8, 1, 2'b01, 20'h10, 20'h0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vt[1] = '{2'd2, 2'd2, 20'h20, 20'h21, 32'h11111111, 32'h22222222, 2, 2, 2'b11, 20'h20, 20'h21, 32'h11111111, 32'h22222222, 32'h0,        32'h0};
        vt[2] = '{2'd1, 2'd1, 20'h20, 20'h21, 32'h0,        32'h0,        3, 2, 2'b00, 20'h20, 20'h21, 32'h0,        32'h0,        32'h11111111, 32'h22222222};
        vt[3] = '{2'd3, 2'd0, 20'h30, 20'h0,  32'h12345678, 32'h0,        1, 1, 2'b01, 20'h30, 20'h0,  32'h12345678, 32'h0,        32'h0,        32'h0};
        vt[4] = '{2'd0, 2'd1, 20'h0,  20'h05, 32'h0,        32'h0,        4, 1, 2'b00, 20'h05, 20'h0,  32'h0,        32'h0,        32'h0,        32'hA5000005};
        vt[5] = '{2'd1, 2'd2, 20'h10, 20'h06, 32'h0,        32'hCAFEF00D, 2, 2, 2'b10, 20'h10, 20'h06, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
        vt[6] = '{2'd2, 2'd1, 20'h21, 20'h21, 32'h0BADF00D, 32'h0,        2, 2, 2'b01, 20'h21, 20'h21, 32'h0BADF00D, 32'h0,        32'h0,        32'h0BADF00D};
        vt[7] = '{2'd0, 2'd3, 20'h0,  20'h31, 32'h0,        32'h55AA55AA, 1, 1, 2'b01, 20'h31, 20'h0,  32'h55AA55AA, 32'h0,        32'h0,        32'h0};

        do_reset();
        chk("rst_busy", {m0_busy, m1_busy}, 0);
        chk("rst_strobes", {s_rd, s_wr}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_err", err_overrun, 0);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Uncontended write latency with an 8-cycle slave busy.
        do_reset();
        blen = 8;
        fall = 0; wr_cnt = 0; rd_cnt = 0; wr_cyc = 0; m1b = 0; b1 = 0;
        wr_addr = '0; wr_data = '0;
        drive(0, 1'b0, 1'b1, 20'h10, 32'hDEADBEEF);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin clear_stb(); b1 = m0_busy; end
            if (s_wr) begin wr_cnt++; wr_cyc = c; wr_addr = s_addr; wr_data = s_wdata; end
            if (s_rd) rd_cnt++;
            if (m1_busy) m1b = 1;
            if (!m0_busy && fall == 0) fall = c;
        end
        chk("lat_busy_at_1", b1, 1);
        chk("lat_wr_count", wr_cnt, 1);
        chk("lat_wr_cycle", wr_cyc, 2);
        chk("lat_wr_addr", wr_addr, 20'h10);
        chk("lat_wr_data", wr_data, 32'hDEADBEEF);
        chk("lat_rd_count", rd_cnt, 0);
        chk("lat_busy_fall", fall, 13);
        chk("lat_m1_busy", m1b, 0);

        // Alternation: m0 reads and m1 writes re-strobe as soon as they are free.
        do_reset();
        blen = 2;
        base = sq.size();
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 600; c++) begin
            clear_stb();
            if (!m0_busy && cnt0 < 6) begin drive(0, 1'b1, 1'b0, 20'h20, 32'h0); cnt0++; end
            if (!m1_busy && cnt1 < 6) begin drive(1, 1'b0, 1'b1, 20'(32'h40 + cnt1), 32'(cnt1)); cnt1++; end
            @(negedge clk);
            if (cnt0 == 6 && cnt1 == 6 && !m0_busy && !m1_busy) break;
        end
        clear_stb();
        chk("alt_nops", sq.size() - base, 12);
        for (int i = 0; i < 12 && base + i < sq.size(); i++)
            chk($sformatf("alt_op%0d_owner_is_m1", i), sq[base+i].wr, 64'(i % 2));
        chk("alt_m0_rdata", m0_rdata, 32'h11111111);

        // Overrun: second m0 strobe while busy is dropped, original completes.
        do_reset();
        blen = 6;
        base = sq.size();
        drive(0, 1'b1, 1'b0, 20'h20, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 || c == 4) clear_stb();
            if (c == 3) drive(0, 1'b1, 1'b0, 20'h05, 32'h0);
            if (c == 4) chk("ovr_err_set", err_overrun, 1);
        end
        chk("ovr_nops", sq.size() - base, 1);
        if (sq.size() > base) chk("ovr_addr", sq[base].addr, 20'h20);
        chk("ovr_rdata", m0_rdata, 32'h11111111);
        chk("ovr_err_sticky", err_overrun, 1);
        chk("ovr_idle", m0_busy, 0);

        // Owner strobe landing in DONE is a fresh request (DONE at cycle 3 + blen + 1).
        do_reset();
        blen = 3;
        base = sq.size();
        drive(0, 1'b1, 1'b0, 20'h20, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 || c == 8) clear_stb();
            if (c == 7) drive(0, 1'b0, 1'b1, 20'h41, 32'h13572468);
            if (c == 8) chk("done_stb_busy", m0_busy, 1);
        end
        chk("done_stb_nops", sq.size() - base, 2);
        if (sq.size() > base + 1) begin
            chk("done_stb_op2_wr", sq[base+1].wr, 1);
            chk("done_stb_op2_addr", sq[base+1].addr, 20'h41);
            chk("done_stb_op2_data", sq[base+1].wdata, 32'h13572468);
        end
        chk("done_stb_err", err_overrun, 0);
        chk("done_stb_rdata", m0_rdata, 32'h11111111);

        // Reset during WAIT of an m1 read, then a fresh read.
        do_reset();
        blen = 10;
        drive(1, 1'b1, 1'b0, 20'h07, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) clear_stb();
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {m0_busy, m1_busy}, 0);
        chk("midrst_strobes", {s_rd, s_wr}, 0);
        chk("midrst_s_addr", s_addr, 0);
        chk("midrst_rdata", m1_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        blen = 2;
        base = sq.size();
        drive(1, 1'b1, 1'b0, 20'h07, 32'h0);
        @(negedge clk);
        clear_stb();
        wait_idle("midrst_again");
        chk("midrst_nops", sq.size() - base, 1);
        chk("midrst_m1_rdata", m1_rdata, 32'hA5000007);

        // Simultaneous rd+wr from m0 after a read: write only, rdata retained.
        do_reset();
        blen = 2;
        drive(0, 1'b1, 1'b0, 20'h05, 32'h0);
        @(negedge clk);
        clear_stb();
        wait_idle("rdwr_first");
        base = sq.size();
        drive(0, 1'b1, 1'b1, 20'h08, 32'h77);
        @(negedge clk);
        clear_stb();
        wait_idle("rdwr_second");
        chk("rdwr_nops", sq.size() - base, 1);
        if (sq.size() > base) chk("rdwr_kind", {sq[base].rd, sq[base].wr}, 2'b01);
        chk("rdwr_m0_rdata", m0_rdata, 32'hA5000005);

        // Random run against the round-robin model on addresses 0x80..0x8F.
        do_reset();
        for (int i = 0; i < 256; i++) rmem[i] = 32'hA500_0000 | 32'(i);
        mst[0] = 0; mst[1] = 0; lastr[0] = '0; lastr[1] = '0; last_g = 1;
        rdptr = sq.size();
        for (int t = 0; t < 3200; t++) begin
            while (rdptr < sq.size()) begin
                logic e0, e1;
                int g;
                op = sq[rdptr];
                rdptr++;
                e0 = (mst[0] == 1) && (mcyc[0] <= op.cyc - 2);
                e1 = (mst[1] == 1) && (mcyc[1] <= op.cyc - 2);
                chk("rand_op_has_requester", 64'(e0 | e1), 64'd1);
                if (e0 || e1) begin
                    g = (e0 && e1) ? 1 - last_g : (e1 ? 1 : 0);
                    chk("rand_op_kind", {op.rd, op.wr}, {~mwr[g], mwr[g]});
                    chk("rand_op_addr", op.addr, maddr[g]);
                    if (mwr[g]) begin
                        chk("rand_op_wdata", op.wdata, mdata[g]);
                        rmem[maddr[g][7:0]] = mdata[g];
                    end else begin
                        lastr[g] = rmem[maddr[g][7:0]];
                    end
                    mst[g] = 2;
                    last_g = g;
                end
            end
            if (mst[0] == 2 && !m0_busy) begin chk("rand_m0_rdata", m0_rdata, lastr[0]); mst[0] = 0; end
            if (mst[1] == 2 && !m1_busy) begin chk("rand_m1_rdata", m1_rdata, lastr[1]); mst[1] = 0; end
            clear_stb();
            blen = 1 + int'($urandom % 4);
            if (t < 3000) begin
                for (int n = 0; n < 2; n++) begin
                    if (mst[n] == 0 && !(n == 0 ? m0_busy : m1_busy) && ($urandom % 3) == 0) begin
                        r = int'($urandom % 5);
                        mwr[n]   = (r >= 2);
                        maddr[n] = 20'(32'h80 + ($urandom % 16));
                        mdata[n] = $urandom;
                        mcyc[n]  = cyc;
                        mst[n]   = 1;
                        drive(n, (r < 2) || (r == 4), r >= 2, maddr[n], mdata[n]);
                    end
                end
            end
            @(negedge clk);
        end
        clear_stb();
        chk("rand_drained", 64'((mst[0] == 0) && (mst[1] == 0)), 64'd1);
        chk("rand_err", err_overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
